// File: rtl/fourway_input_sequencer.sv
// fourway_input_sequencer: time-multiplexed 4-way joystick conditioner.
// Each ce strobe snapshots all players and the diagonal mode, then sweeps
// one player per clock through a shared settle filter, history tracker and
// diagonal resolver. Nibble bits are {up,down,left,right}.
// Optional build macro: FOURWAY_OPPOSITE_CANCEL_EN clears opposing
// direction pairs (up+down, left+right) before the settle filter.
module fourway_input_sequencer #(
    parameter int NUM_PLAYERS          = 2,
    parameter int SETTLE               = 2,
    parameter int PDIP_FAVOR_DIRECTION = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic [4*NUM_PLAYERS-1:0] joy_in,
    input  logic [3:0]               m_mode,
    output logic [4*NUM_PLAYERS-1:0] joy_out,
    output logic                     out_valid,
    output logic                     overrun
);

    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [PW-1:0] LAST_P   = PW'(NUM_PLAYERS - 1);
    localparam logic [CW:0]   SETTLE_W = (CW + 1)'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;
    typedef enum logic [3:0] {
        M_DISABLED   = 4'd0,
        M_PREDICTION = 4'd1,
        M_CORRECTION = 4'd2,
        M_VERTICAL   = 4'd3,
        M_HORIZONTAL = 4'd4,
        M_CLEAR      = 4'd5
    } mode_t;

    state_t                     state_q, state_d;
    logic [PW-1:0]              p_q, p_d;
    logic [4*NUM_PLAYERS-1:0]   snap_q, snap_d;
    logic [3:0]                 mode_q, mode_d;
    logic [4*NUM_PLAYERS-1:0]   joy_q, joy_d;
    logic                       out_valid_q, out_valid_d;
    logic                       overrun_q, overrun_d;
    logic [3:0]                 cand_q [NUM_PLAYERS];
    logic [3:0]                 cand_d [NUM_PLAYERS];
    logic [CW-1:0]              cnt_q  [NUM_PLAYERS];
    logic [CW-1:0]              cnt_d  [NUM_PLAYERS];
    logic [3:0]                 acc_q  [NUM_PLAYERS];
    logic [3:0]                 acc_d  [NUM_PLAYERS];
    logic [3:0]                 old_q  [NUM_PLAYERS];
    logic [3:0]                 old_d  [NUM_PLAYERS];

    function automatic logic is_diag(input logic [3:0] v);
        return (v[3] | v[2]) & (v[1] | v[0]);
    endfunction

    function automatic logic [3:0] cancel_opp(input logic [3:0] v);
        logic [3:0] r;
        r = v;
`ifdef FOURWAY_OPPOSITE_CANCEL_EN
        if (v[3] && v[2]) r[3:2] = 2'b00;
        if (v[1] && v[0]) r[1:0] = 2'b00;
`endif
        return r;
    endfunction

    function automatic logic [3:0] resolve(input logic [3:0] a, input logic [3:0] o,
                                           input logic [3:0] mode);
        logic [3:0] r;
        r = a;
        if (is_diag(a)) begin
            case (mode)
                M_PREDICTION: r = a & ~o;
                M_CORRECTION: r = o;
                M_VERTICAL:   r = a & 4'b1100;
                M_HORIZONTAL: r = a & 4'b0011;
                M_CLEAR:      r = '0;
                default:      r = a;
            endcase
        end
        if (is_diag(r)) begin
            r = (PDIP_FAVOR_DIRECTION != 0) ? (r & 4'b1100) : (r & 4'b0011);
        end
        return r;
    endfunction

    // Next-state: sweep control, per-player settle/history/resolution for player p.
    always_comb begin
        logic [3:0] s;
        logic [3:0] a;
        logic [3:0] o;
        logic       accept;
        s           = '0;
        a           = '0;
        o           = '0;
        accept      = 1'b0;
        state_d     = state_q;
        p_d         = p_q;
        snap_d      = snap_q;
        mode_d      = mode_q;
        joy_d       = joy_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        old_d       = old_q;

        if (ce && state_q != S_IDLE) overrun_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (ce) begin
                    snap_d  = joy_in;
                    mode_d  = m_mode;
                    p_d     = '0;
                    state_d = S_EVAL;
                    // History is cleared at snapshot time; no player has been
                    // evaluated yet, so this precedes every resolution in the sweep.
                    if (m_mode != mode_q) begin
                        for (int unsigned i = 0; i < NUM_PLAYERS; i++) old_d[i] = '0;
                    end
                end
            end
            S_EVAL: begin
                for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                    if (p_q == PW'(i)) begin
                        s      = cancel_opp(snap_q[4*i +: 4]);
                        a      = acc_q[i];
                        o      = old_q[i];
                        accept = 1'b0;
                        if (s != cand_q[i]) begin
                            cand_d[i] = s;
                            cnt_d[i]  = '0;
                            accept    = (SETTLE == 0);
                        end else if ({1'b0, cnt_q[i]} < SETTLE_W) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                            accept   = (({1'b0, cnt_q[i]} + 1'b1) == SETTLE_W);
                        end else begin
                            accept = 1'b1;
                        end
                        if (accept && s != a) begin
                            o = a;
                            a = s;
                        end
                        acc_d[i]          = a;
                        old_d[i]          = o;
                        joy_d[4*i +: 4]   = resolve(a, o, mode_q);
                    end
                end
                if (p_q == LAST_P) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            snap_q      <= '0;
            mode_q      <= '0;
            joy_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                cand_q[i] <= '0;
                cnt_q[i]  <= '0;
                acc_q[i]  <= '0;
                old_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            snap_q      <= snap_d;
            mode_q      <= mode_d;
            joy_q       <= joy_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                cand_q[i] <= cand_d[i];
                cnt_q[i]  <= cnt_d[i];
                acc_q[i]  <= acc_d[i];
                old_q[i]  <= old_d[i];
            end
        end
    end

    assign joy_out   = joy_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fourway_input_sequencer.sv
// Testbench for fourway_input_sequencer: two instances with different
// parameters, a sweep-level reference model, per-cycle comparison, and
// directed literal checks. Honors FOURWAY_OPPOSITE_CANCEL_EN if defined.
module tb_fourway_input_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic [11:0] joy = '0;
    logic [3:0]  mode = '0;
    logic [7:0]  jo0;
    logic [11:0] jo1;
    logic        ov0, ov1, ovr0, ovr1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int vc0 = 0;
    int vc1 = 0;

    fourway_input_sequencer #(.NUM_PLAYERS(2), .SETTLE(0), .PDIP_FAVOR_DIRECTION(0)) u0 (
        .clk(clk), .reset(reset), .ce(ce), .joy_in(joy[7:0]), .m_mode(mode),
        .joy_out(jo0), .out_valid(ov0), .overrun(ovr0));

    fourway_input_sequencer #(.NUM_PLAYERS(3), .SETTLE(2), .PDIP_FAVOR_DIRECTION(1)) u1 (
        .clk(clk), .reset(reset), .ce(ce), .joy_in(joy), .m_mode(mode),
        .joy_out(jo1), .out_valid(ov1), .overrun(ovr1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (sweep level) ----------------
    int NP[2] = '{2, 3};
    int SP[2] = '{0, 2};
    int FP[2] = '{0, 1};

    logic [3:0] m_runv [2][4];
    int         m_runl [2][4];
    logic [3:0] m_acc  [2][4];
    logic [3:0] m_old  [2][4];
    logic [3:0] m_pv   [2][4];
    int         m_pe   [2][4];
    logic [3:0] m_exp  [2][4];
    int         m_lastmode [2];
    int         m_busy [2];
    int         m_vedge[2];
    bit         m_ovr  [2];
    int         cyc = 0;

    function automatic logic [3:0] m_cancel(input logic [3:0] v);
        logic [3:0] r;
        r = v;
`ifdef FOURWAY_OPPOSITE_CANCEL_EN
        if (v[3] && v[2]) r[3:2] = 2'b00;
        if (v[1] && v[0]) r[1:0] = 2'b00;
`endif
        return r;
    endfunction

    function automatic bit m_diag(input logic [3:0] v);
        return ((v[3] || v[2]) && (v[1] || v[0]));
    endfunction

    function automatic logic [3:0] m_resolve(input logic [3:0] a, input logic [3:0] o,
                                             input int md, input int fav);
        logic [3:0] r;
        r = a;
        if (m_diag(a)) begin
            if (md == 1)      r = a & ~o;
            else if (md == 2) r = o;
            else if (md == 3) r = {a[3:2], 2'b00};
            else if (md == 4) r = {2'b00, a[1:0]};
            else if (md == 5) r = 4'b0000;
        end
        if (m_diag(r)) r = (fav != 0) ? {r[3:2], 2'b00} : {2'b00, r[1:0]};
        return r;
    endfunction

    // Model: whole sweep computed at the accepting edge, outputs scheduled by edge number.
    always @(posedge clk) begin
        logic [3:0] s;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int p = 0; p < 4; p++) begin
                    m_runv[d][p] = '0; m_runl[d][p] = 1; m_acc[d][p] = '0;
                    m_old[d][p] = '0;  m_exp[d][p] = '0; m_pe[d][p] = -1;
                end
                m_lastmode[d] = 0; m_busy[d] = -1; m_vedge[d] = -1; m_ovr[d] = 1'b0;
            end else begin
                for (int p = 0; p < 4; p++) if (m_pe[d][p] == cyc) m_exp[d][p] = m_pv[d][p];
                if (ce) begin
                    if (cyc <= m_busy[d]) m_ovr[d] = 1'b1;
                    else begin
                        if (int'(mode) != m_lastmode[d])
                            for (int p = 0; p < 4; p++) m_old[d][p] = '0;
                        m_lastmode[d] = int'(mode);
                        for (int p = 0; p < NP[d]; p++) begin
                            s = m_cancel(joy[4*p +: 4]);
                            if (s == m_runv[d][p]) begin
                                if (m_runl[d][p] < 100) m_runl[d][p]++;
                            end else begin
                                m_runv[d][p] = s; m_runl[d][p] = 1;
                            end
                            if (m_runl[d][p] >= SP[d] + 1 && s != m_acc[d][p]) begin
                                m_old[d][p] = m_acc[d][p];
                                m_acc[d][p] = s;
                            end
                            m_pv[d][p] = m_resolve(m_acc[d][p], m_old[d][p], int'(mode), FP[d]);
                            m_pe[d][p] = cyc + 1 + p;
                        end
                        m_vedge[d] = cyc + NP[d];
                        m_busy[d]  = cyc + NP[d] + 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model, on the falling edge.
    always @(negedge clk) begin
        logic [7:0]  e0;
        logic [11:0] e1;
        if (chk_en) begin
            e0 = {m_exp[0][1], m_exp[0][0]};
            e1 = {m_exp[1][2], m_exp[1][1], m_exp[1][0]};
            chk("joy0",   {4'h0, jo0}, {4'h0, e0});
            chk("valid0", {11'h0, ov0}, {11'h0, cyc == m_vedge[0]});
            chk("ovr0",   {11'h0, ovr0}, {11'h0, m_ovr[0]});
            chk("joy1",   jo1, e1);
            chk("valid1", {11'h0, ov1}, {11'h0, cyc == m_vedge[1]});
            chk("ovr1",   {11'h0, ovr1}, {11'h0, m_ovr[1]});
            if (ov0 === 1'b1) vc0++;
            if (ov1 === 1'b1) vc1++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk); reset = 1'b1; ce = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic sweep(input logic [11:0] j, input logic [3:0] m);
        @(negedge clk); joy = j; mode = m; ce = 1'b1;
        @(negedge clk); ce = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic step3(input logic [3:0] n, input logic [3:0] m);
        repeat (3) sweep({8'h00, n}, m);
    endtask

    initial begin
        int vb;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_joy0", {4'h0, jo0}, 12'h000);
        chk("rst_ovr0", {11'h0, ovr0}, 12'h000);

        // Power-up sweep with 8'h21, player latency one edge each.
        vb = vc0;
        @(negedge clk); joy = 12'h021; mode = 4'd0; ce = 1'b1;
        @(negedge clk); ce = 1'b0;
        @(negedge clk); chk("lit_pwr_k1", {4'h0, jo0}, 12'h001);
        @(negedge clk); chk("lit_pwr_k2", {4'h0, jo0}, 12'h021);
        chk("lit_pwr_valid", {11'h0, ov0}, 12'h001);
        repeat (4) @(negedge clk);
        chk("lit_pwr_vcnt", 12'(vc0 - vb), 12'h001);
        chk("lit_pwr_ovr", {11'h0, ovr0}, 12'h000);

        // Mode sequences on player 0: up, then up+left.
        step3(4'b1000, 4'd1); step3(4'b1010, 4'd1);
        chk("lit_pred0", {8'h0, jo0[3:0]}, 12'h002);
        chk("lit_pred1", {8'h0, jo1[3:0]}, 12'h002);
        chk("lit_pred_model", {8'h0, m_exp[0][0]}, 12'h002);
        step3(4'b1010, 4'd1);
        chk("lit_pred_hold", {8'h0, jo0[3:0]}, 12'h002);
        step3(4'b1000, 4'd2); step3(4'b1010, 4'd2);
        chk("lit_corr0", {8'h0, jo0[3:0]}, 12'h008);
        chk("lit_corr1", {8'h0, jo1[3:0]}, 12'h008);
        step3(4'b1000, 4'd5); step3(4'b1010, 4'd5);
        chk("lit_clear0", {8'h0, jo0[3:0]}, 12'h000);
        chk("lit_clear1", {8'h0, jo1[3:0]}, 12'h000);
        step3(4'b1000, 4'd0); step3(4'b1010, 4'd0);
        chk("lit_dis_fav0", {8'h0, jo0[3:0]}, 12'h002);
        chk("lit_dis_fav1", {8'h0, jo1[3:0]}, 12'h008);

        // Settle filter on the SETTLE=2 instance.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sweep(12'h001, 4'd0); chk("lit_alt_a", {8'h0, jo1[3:0]}, 12'h000);
            sweep(12'h000, 4'd0); chk("lit_alt_b", {8'h0, jo1[3:0]}, 12'h000);
        end
        sweep(12'h001, 4'd0); chk("lit_hold1", {8'h0, jo1[3:0]}, 12'h000);
        sweep(12'h001, 4'd0); chk("lit_hold2", {8'h0, jo1[3:0]}, 12'h000);
        sweep(12'h001, 4'd0); chk("lit_hold3", {8'h0, jo1[3:0]}, 12'h001);

        // Overrun: second ce one cycle after the first.
        do_reset();
        vb = vc0;
        @(negedge clk); joy = 12'h021; ce = 1'b1;
        @(negedge clk); ce = 1'b1;
        @(negedge clk); ce = 1'b0;
        repeat (6) @(negedge clk);
        chk("lit_ovr0", {11'h0, ovr0}, 12'h001);
        chk("lit_ovr1", {11'h0, ovr1}, 12'h001);
        chk("lit_ovr_vcnt", 12'(vc0 - vb), 12'h001);
        repeat (3) @(negedge clk);
        chk("lit_ovr_sticky", {11'h0, ovr0}, 12'h001);
        do_reset();
        @(negedge clk);
        chk("lit_ovr_clr", {11'h0, ovr0}, 12'h000);

        // Reset during the EVAL cycle of player 1.
        vb = vc0;
        @(negedge clk); joy = 12'h021; mode = 4'd0; ce = 1'b1;
        @(negedge clk); ce = 1'b0;
        @(negedge clk); chk("lit_mid_p0", {4'h0, jo0}, 12'h001); reset = 1'b1;
        @(negedge clk); chk("lit_mid_joy", {4'h0, jo0}, 12'h000);
        chk("lit_mid_valid", {11'h0, ov0}, 12'h000); reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("lit_mid_vcnt", 12'(vc0 - vb), 12'h000);
        sweep(12'h021, 4'd0);
        chk("lit_mid_again", {4'h0, jo0}, 12'h021);

`ifdef FOURWAY_OPPOSITE_CANCEL_EN
        sweep(12'h00E, 4'd0);
        chk("lit_cancel", {8'h0, jo0[3:0]}, 12'h002);
`else
        sweep(12'h00C, 4'd1);
        chk("lit_nocancel", {8'h0, jo0[3:0]}, 12'h00C);
`endif

        // Randomized traffic; joystick values are held for runs so the settle filter accepts.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            ce    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) joy = 12'($urandom);
            if ($urandom_range(0, 29) == 0) mode = 4'($urandom_range(0, 7));
            else if ($urandom_range(0, 199) == 0) mode = 4'd15;
        end
        @(negedge clk); reset = 1'b0; ce = 1'b0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fourway_input_sequencer.md
Name: fourway_input_sequencer

Overview:
- Time-multiplexed controller for 4-way joystick conditioning across NUM_PLAYERS players.
- On each sample strobe, sweeps the players one per clock through a single shared diagonal resolver. For each player it applies a settle filter (debounce), keeps that player's direction history, and registers the conditioned direction.
- Sits between the MiSTer joystick inputs and the game core's control inputs.

Parameters:
- NUM_PLAYERS, 2, number of players swept; range 1..4.
- SETTLE, 2, number of consecutive identical sweeps needed before a raw change is accepted; 0 = accept immediately.
- PDIP_FAVOR_DIRECTION, 0, tie-break for a diagonal that survives mode resolution; 0 = keep horizontal, 1 = keep vertical.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- ce  in  1  sample strobe (e.g. once per line or frame).
- joy_in  in  4*NUM_PLAYERS  raw directions; nibble p = player p, bits {up,down,left,right}.
- m_mode  in  4  diagonal mode: 0 DISABLED, 1 PREDICTION, 2 CORRECTION, 3 VERTICAL, 4 HORIZONTAL, 5 CLEAR; values 6..15 behave as DISABLED.
- joy_out  out  4*NUM_PLAYERS  conditioned directions, registered.
- out_valid  out  1  one-cycle pulse when a sweep completes.
- overrun  out  1  sticky; set when ce arrives while busy.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset clears: joy_out=0, out_valid=0, overrun=0, and for every player cand/cnt/acc/old=0. FSM goes to IDLE.
- FSM states IDLE, EVAL, DONE.
  - IDLE: when ce=1, snapshot joy_in and m_mode, set p=0, go to EVAL.
  - EVAL: processes player p in that cycle. If p==NUM_PLAYERS-1, go to DONE; otherwise p++.
  - DONE: out_valid=1 for exactly this cycle, then go to IDLE.
- Latency: ce sampled at edge k. joy_out[p] is updated at edge k+1+p. out_valid is high in the cycle after edge k+NUM_PLAYERS. A sweep occupies NUM_PLAYERS+2 cycles including the IDLE cycle.
- ce while in EVAL or DONE: ignored, and overrun<=1. Only reset clears overrun.
- Per-player settle filter, applied in that player's EVAL cycle, with s = snapshot nibble:
  - s!=cand: cand<=s, cnt<=0. Accept s only if SETTLE==0.
  - s==cand and cnt<SETTLE: cnt<=cnt+1. Accept cand if cnt+1==SETTLE.
  - s==cand and cnt==SETTLE: no counter change; treated as accepted-stable.
  - cnt width is clog2(SETTLE+1), minimum 1. It saturates and never wraps.
- Accepting a value v with v!=acc updates history: old<=acc, acc<=v. Accepting v==acc changes nothing.
- Resolution each EVAL, using acc (a) and old (o) after the update above:
  - A nibble is diagonal when it has (up|down) set and (left|right) set.
  - Non-diagonal, or mode DISABLED/unknown: r=a.
  - PREDICTION: r = a & ~o.
  - CORRECTION: r = o.
  - VERTICAL: r = a & {up,down}.
  - HORIZONTAL: r = a & {left,right}.
  - CLEAR: r = 0.
  - If r is still diagonal: drop the non-favored axis per PDIP_FAVOR_DIRECTION.
  - joy_out[p] <= r.
- m_mode is used from the snapshot, so a mid-sweep change takes effect on the next sweep. A snapshotted m_mode that differs from the previous sweep's mode clears old for all players during that sweep, before resolution.
- Reset asserted mid-sweep wins: all state clears, FSM to IDLE, and no out_valid pulse.

Optional Feature:
- FOURWAY_OPPOSITE_CANCEL_EN.
- Defined: before the settle filter, a nibble with up&down both set has both cleared, and likewise left&right. Example: 4'b1110 becomes 4'b0010.
- Undefined: opposites pass through unchanged, and a nibble such as 1100 is treated as non-diagonal and forwarded unchanged.

Test Plan:
- Reset, then ce with joy_in=8'h21, SETTLE=0 → joy_out[3:0]=0001 at edge k+1, joy_out[7:4]=0010 at edge k+2, out_valid pulse once, overrun=0.
- Player 0, SETTLE=0, mode 1: sweep up (1000), then up+left (1010) → joy_out=0010. Repeat 1010 → stays 0010, no oscillation.
- Mode 2, same sequence → joy_out=1000. Mode 5 → 0000. Mode 0 with PDIP_FAVOR_DIRECTION=0 → 0010; with it set to 1 → 1000.
- SETTLE=2, alternate 0001/0000 on every sweep → joy_out stays 0000. Hold 0001 → joy_out=0001 after the 3rd identical sweep.
- ce pulsed again 1 cycle after the first ce, NUM_PLAYERS=2 → second ce ignored, overrun=1 until reset, exactly one out_valid.
- Reset asserted in EVAL for p=1 → joy_out=0 next edge, no out_valid; next ce behaves as after power-up. With FOURWAY_OPPOSITE_CANCEL_EN, input 1110 → 0010.
